ntt_addr_gen: RTL

- Butterfly sequencer sitting directly upstream of the polynomial unit's butterfly datapath and NTT RAM.
- On start, walks all 7 Kyber NTT or INTT layers, one butterfly per cycle, over a 256-coefficient polynomial.
- Per butterfly it emits the RAM read address pair and the zeta ROM index.
- Emits the matching write-back address pair after a fixed datapath latency, with a hazard drain between layers.

---
 rtl/poly_pkg.sv | 39 +++
 rtl/ntt_addr_gen_if.sv | 30 +++
 rtl/ntt_wb_delay.sv | 27 ++
 rtl/ntt_addr_gen.sv | 108 ++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared polynomial-unit definitions: mode encodings, sizing and the
// NTT butterfly address/twiddle helper used by the sequencer.
package poly_pkg;

  localparam int unsigned LOGN  = 8;
  localparam int unsigned NCOEF = 1 << LOGN;

  localparam logic [1:0] M_DATAIN = 2'd0;
  localparam logic [1:0] M_NTT    = 2'd1;
  localparam logic [1:0] M_INTT   = 2'd2;
  localparam logic [1:0] M_BYPASS = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} gen_state_e;

  typedef struct packed {
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    logic [6:0]      tw;
  } bfly_addr_t;

  // Insert a zero at bit s of the butterfly index to get the lower operand.
  function automatic bfly_addr_t bfly_addr(input logic intt, input logic [2:0] layer,
                                           input logic [6:0] bfly);
    logic [2:0]      s;
    logic [LOGN-1:0] len;
    logic [LOGN-1:0] bx;
    logic [LOGN-1:0] grp;
    bfly_addr_t      r;
    s    = intt ? (layer + 3'd1) : (3'd7 - layer);
    len  = 8'd1 << s;
    bx   = {1'b0, bfly};
    grp  = bx >> s;
    r.a  = ((grp << 1) << s) | (bx & (len - 8'd1));
    r.b  = r.a | len;
    r.tw = intt ? 7'((8'd128 >> layer) - 8'd1 - grp) : 7'((8'd1 << layer) + grp);
    return r;
  endfunction

endpackage

// File: rtl/ntt_addr_gen_if.sv
// Control and address bus between the NTT sequencer and its controller.
interface ntt_addr_gen_if import poly_pkg::*; ();

  logic            start;
  logic [1:0]      mode;
  logic            stall;
  logic            rd_valid;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [6:0]      tw_idx;
  logic            wr_valid;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;
  logic [2:0]      layer;
  logic            busy;
  logic            done;

  modport master (
    output start, mode, stall,
    input  rd_valid, rd_addr_a, rd_addr_b, tw_idx, wr_valid, wr_addr_a, wr_addr_b,
           layer, busy, done
  );

  modport slave (
    input  start, mode, stall,
    output rd_valid, rd_addr_a, rd_addr_b, tw_idx, wr_valid, wr_addr_a, wr_addr_b,
           layer, busy, done
  );

endinterface

// File: rtl/ntt_wb_delay.sv
// Stall-aware shift register aligning write-back addresses with the
// butterfly datapath latency.
module ntt_wb_delay #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned Width = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else if (en_i) begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[LAT-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// Kyber NTT/INTT butterfly sequencer: issues read pairs and twiddle indices
// one butterfly per cycle and replays write-back pairs after LAT cycles.
module ntt_addr_gen import poly_pkg::*; #(
  parameter int unsigned LAT = 4
) (
  input logic           clk,
  input logic           rst,
  ntt_addr_gen_if.slave ag
);

  gen_state_e state_q, state_d;
  logic [6:0] bfly_q, bfly_d;
  logic [2:0] layer_q, layer_d;
  logic       intt_q, intt_d;
  logic [3:0] drain_q, drain_d;
  bfly_addr_t rd_q, rd_d;
  logic       run;
  logic       rd_valid;
  logic [2*LOGN:0] wb_q;

  assign run = ~ag.stall;

  always_comb begin
    state_d = state_q;
    bfly_d  = bfly_q;
    layer_d = layer_q;
    intt_d  = intt_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (ag.start && (ag.mode == M_NTT || ag.mode == M_INTT)) begin
          state_d = StIssue;
          intt_d  = (ag.mode == M_INTT);
          bfly_d  = 7'd0;
          layer_d = 3'd0;
        end
      end
      StIssue: begin
        if (bfly_q == 7'd127) begin
          state_d = StDrain;
          drain_d = 4'd0;
        end else begin
          bfly_d = bfly_q + 7'd1;
        end
      end
      StDrain: begin
        if (drain_q == 4'(LAT - 1)) begin
          if (layer_q == 3'd6) begin
            state_d = StFinish;
          end else begin
            state_d = StIssue;
            layer_d = layer_q + 3'd1;
            bfly_d  = 7'd0;
          end
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    rd_d = bfly_addr(intt_d, layer_d, bfly_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bfly_q  <= '0;
      layer_q <= '0;
      intt_q  <= 1'b0;
      drain_q <= '0;
      rd_q    <= '0;
    end else if (run) begin
      state_q <= state_d;
      bfly_q  <= bfly_d;
      layer_q <= layer_d;
      intt_q  <= intt_d;
      drain_q <= drain_d;
      // Addresses only move when the next cycle issues, so they hold elsewhere.
      if (state_d == StIssue) rd_q <= rd_d;
    end
  end

  assign rd_valid = (state_q == StIssue) && run;

  ntt_wb_delay #(
    .LAT   (LAT),
    .Width (2 * LOGN + 1)
  ) u_wb_delay (
    .clk  (clk),
    .rst  (rst),
    .en_i (run),
    .d_i  ({rd_valid, rd_q.a, rd_q.b}),
    .q_o  (wb_q)
  );

  assign ag.rd_valid  = rd_valid;
  assign ag.rd_addr_a = rd_q.a;
  assign ag.rd_addr_b = rd_q.b;
  assign ag.tw_idx    = rd_q.tw;
  assign ag.wr_valid  = wb_q[2*LOGN] && run;
  assign ag.wr_addr_a = wb_q[2*LOGN-1:LOGN];
  assign ag.wr_addr_b = wb_q[LOGN-1:0];
  assign ag.layer     = layer_q;
  assign ag.busy      = (state_q == StIssue) || (state_q == StDrain);
  assign ag.done      = (state_q == StFinish) && run;

endmodule
